// File: rtl/button_irq_host.sv
// button_irq_host
//   Hardware replacement for a button ISR. Services an Avalon-MM push-button
//   PIO: on irq it reads the edge-capture register (addr 3), clears it, counts
//   a real press, then holds off for a debounce interval. Any edges captured
//   during the hold-off are discarded by a final clear before returning to idle.
//
//   PIO register map: 0 data, 2 irq mask, 3 edge capture.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous reset, active-high
//   irq            in   PIO interrupt request
//   avm_address    out  PIO register address
//   avm_chipselect out  PIO chip select
//   avm_write_n    out  PIO write strobe, active-low
//   avm_writedata  out  PIO write data
//   avm_readdata   in   PIO read data (registered in the PIO, valid one cycle
//                       after the address is presented)
//   press_count    out  serviced press count, wraps mod 2^COUNT_W
//   press_pulse    out  one-cycle strobe per counted press
//   button_level   out  last sampled button level (only with the macro below)
//   busy           out  high whenever the FSM is not idle
//
// Build option
//   BUTTON_LEVEL_READBACK_EN : after each service, read the PIO data register
//   (addr 0) and expose bit 0 on button_level.
module button_irq_host #(
  parameter logic [31:0] IRQ_MASK_VAL   = 32'd1,
  parameter int          HOLDOFF_CYCLES = 500000,
  parameter int          COUNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               irq,
  output logic [1:0]         avm_address,
  output logic               avm_chipselect,
  output logic               avm_write_n,
  output logic [31:0]        avm_writedata,
  input  logic [31:0]        avm_readdata,
  output logic [COUNT_W-1:0] press_count,
  output logic               press_pulse,
`ifdef BUTTON_LEVEL_READBACK_EN
  output logic               button_level,
`endif
  output logic               busy
);

  localparam int HC_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD =
    HC_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    S_INIT_MASK,
    S_INIT_CLR,
    S_IDLE,
    S_RD0,
    S_RD1,
    S_CLR,
    S_HOLD,
`ifdef BUTTON_LEVEL_READBACK_EN
    S_HOLD_CLR,
    S_LV0,
    S_LV1
`else
    S_HOLD_CLR
`endif
  } state_t;

  state_t               state_q, state_d;
  logic                 init_go_q;
  logic [HC_W-1:0]      hold_q, hold_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 pulse_q, pulse_d;
  logic [1:0]           addr_q, addr_d;
  logic                 cs_q, cs_d;
  logic                 wn_q, wn_d;
  logic [31:0]          wd_q, wd_d;
  logic                 busy_q, busy_d;
`ifdef BUTTON_LEVEL_READBACK_EN
  logic                 level_q, level_d;
`endif

  // Only bit 0 of the PIO registers carries information here.
  logic unused_rdata;
  assign unused_rdata = ^avm_readdata[31:1];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    count_d = count_q;
    pulse_d = 1'b0;
`ifdef BUTTON_LEVEL_READBACK_EN
    level_d = level_q;
`endif

    case (state_q)
      // The first clock after reset is spent presenting the mask write;
      // without init_go_q the look-ahead bus decode would skip it.
      S_INIT_MASK: if (init_go_q) state_d = S_INIT_CLR;
      S_INIT_CLR:  state_d = S_IDLE;
      S_IDLE:      if (irq) state_d = S_RD0;
      S_RD0:       state_d = S_RD1;
      S_RD1: begin
        state_d = S_CLR;
        // The pulse and count are registered here so they appear during S_CLR.
        if (avm_readdata[0]) begin
          count_d = count_q + COUNT_W'(1);
          pulse_d = 1'b1;
        end
      end
      S_CLR: begin
        if (HOLDOFF_CYCLES == 0) begin
`ifdef BUTTON_LEVEL_READBACK_EN
          state_d = S_LV0;
`else
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = S_HOLD_CLR;
        else              hold_d  = hold_q - HC_W'(1);
      end
`ifdef BUTTON_LEVEL_READBACK_EN
      S_HOLD_CLR: state_d = S_LV0;
      S_LV0:      state_d = S_LV1;
      S_LV1: begin
        state_d = S_IDLE;
        level_d = avm_readdata[0];
      end
`else
      S_HOLD_CLR: state_d = S_IDLE;
`endif
      default:    state_d = S_INIT_MASK;
    endcase

    // Bus outputs are decoded from the next state and registered, so the
    // transfer on the bus always matches the state currently held.
    addr_d = 2'd3;
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    wd_d   = '0;
    case (state_d)
      S_INIT_MASK: begin
        addr_d = 2'd2;
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        wd_d   = IRQ_MASK_VAL;
      end
      S_INIT_CLR, S_CLR, S_HOLD_CLR: begin
        cs_d = 1'b1;
        wn_d = 1'b0;
        wd_d = 32'd1;
      end
      S_RD0, S_RD1: cs_d = 1'b1;
`ifdef BUTTON_LEVEL_READBACK_EN
      S_LV0, S_LV1: begin
        addr_d = 2'd0;
        cs_d   = 1'b1;
      end
`endif
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_INIT_MASK;
      init_go_q <= 1'b0;
      hold_q    <= '0;
      count_q   <= '0;
      pulse_q   <= 1'b0;
      addr_q    <= 2'd0;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      wd_q      <= '0;
      busy_q    <= 1'b1;
`ifdef BUTTON_LEVEL_READBACK_EN
      level_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      init_go_q <= 1'b1;
      hold_q    <= hold_d;
      count_q   <= count_d;
      pulse_q   <= pulse_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      wn_q      <= wn_d;
      wd_q      <= wd_d;
      busy_q    <= busy_d;
`ifdef BUTTON_LEVEL_READBACK_EN
      level_q   <= level_d;
`endif
    end
  end

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wd_q;
  assign press_count    = count_q;
  assign press_pulse    = pulse_q;
  assign busy           = busy_q;
`ifdef BUTTON_LEVEL_READBACK_EN
  assign button_level   = level_q;
`endif

endmodule

// File: tb/tb_button_irq_host.sv
// Bench for button_irq_host: a registered PIO responder model drives irq and
// readdata; a timeline model predicts every bus/output value per cycle from
// the cycle at which each service started.
module tb_button_irq_host;

  localparam int H  = 8;
  localparam int CW = 2;
`ifdef BUTTON_LEVEL_READBACK_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAST     = 3 + H + EXTRA;   // last service offset before idle
  localparam int BUSY_LAT = 13 + EXTRA;      // irq rise to busy low

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          irq;
  logic [1:0]    avm_address;
  logic          avm_chipselect;
  logic          avm_write_n;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata;
  logic [CW-1:0] press_count;
  logic          press_pulse;
  logic          busy;
`ifdef BUTTON_LEVEL_READBACK_EN
  logic          button_level;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_irq_host #(
    .IRQ_MASK_VAL  (32'd1),
    .HOLDOFF_CYCLES(H),
    .COUNT_W       (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .irq           (irq),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n   (avm_write_n),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata),
    .press_count   (press_count),
    .press_pulse   (press_pulse),
`ifdef BUTTON_LEVEL_READBACK_EN
    .button_level  (button_level),
`endif
    .busy          (busy)
  );

  // PIO responder: falling-edge capture on bit 0, clear wins over a new edge,
  // readdata registered from the presented address every cycle.
  logic        in_port   = 1'b1;
  logic        irq_force = 1'b0;
  logic        pio_prev  = 1'b1;
  logic        pio_cap   = 1'b0;
  logic [31:0] pio_mask  = 32'd0;
  logic [31:0] pio_rd    = 32'd0;

  always @(posedge clk) begin
    pio_prev <= in_port;
    if (avm_chipselect && !avm_write_n && avm_address == 2'd2) pio_mask <= avm_writedata;
    if (avm_chipselect && !avm_write_n && avm_address == 2'd3 && avm_writedata[0])
      pio_cap <= 1'b0;
    else if (pio_prev && !in_port)
      pio_cap <= 1'b1;
    case (avm_address)
      2'd0:    pio_rd <= {31'd0, in_port};
      2'd2:    pio_rd <= pio_mask;
      2'd3:    pio_rd <= {31'd0, pio_cap};
      default: pio_rd <= 32'd0;
    endcase
  end

  assign irq          = (pio_cap & pio_mask[0]) | irq_force;
  assign avm_readdata = pio_rd;

  // Timeline model. mk = clock edges since reset release. Edges 1 and 2 are
  // the init writes; from edge 3 on the host is idle unless inside a service
  // window [m_s, m_s+LAST], where m_s is the edge that accepted irq.
  int   mk     = 0;
  int   m_s    = -100;
  int   m_cnt  = 0;
  logic m_edge = 1'b0;
  logic m_lvl  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mk     <= 0;
      m_s    <= -100;
      m_cnt  <= 0;
      m_edge <= 1'b0;
      m_lvl  <= 1'b0;
    end else begin
      mk <= mk + 1;
      if (mk >= 3 && !(mk >= m_s && mk <= m_s + LAST) && irq === 1'b1)
        m_s <= mk + 1;
      if (mk + 1 == m_s + 2) begin
        m_edge <= pio_rd[0];
        if (pio_rd[0]) m_cnt <= (m_cnt + 1) % (1 << CW);
      end
      if (EXTRA > 0 && mk + 1 == m_s + LAST + 1) m_lvl <= pio_rd[0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int          d;
    logic [1:0]  ea;
    logic        ecs, ewn, ebusy, epulse;
    logic [31:0] ewd;
    ea = 2'd3; ecs = 1'b0; ewn = 1'b1; ewd = 32'd0; ebusy = 1'b0; epulse = 1'b0;
    if (reset) begin
      ea = 2'd0; ebusy = 1'b1;
    end else if (mk == 1) begin
      ea = 2'd2; ecs = 1'b1; ewn = 1'b0; ewd = 32'd1; ebusy = 1'b1;
    end else if (mk == 2) begin
      ecs = 1'b1; ewn = 1'b0; ewd = 32'd1; ebusy = 1'b1;
    end else begin
      d = mk - m_s;
      if (d >= 0 && d <= LAST) begin
        ebusy = 1'b1;
        if (d <= 1) ecs = 1'b1;
        else if (d == 2) begin
          ecs = 1'b1; ewn = 1'b0; ewd = 32'd1; epulse = m_edge;
        end else if (d == 3 + H) begin
          ecs = 1'b1; ewn = 1'b0; ewd = 32'd1;
        end else if (d > 3 + H) begin
          ecs = 1'b1; ea = 2'd0;
        end
      end
    end
    chk("cyc_address", avm_address, ea);
    chk("cyc_chipselect", avm_chipselect, ecs);
    chk("cyc_write_n", avm_write_n, ewn);
    chk("cyc_writedata", avm_writedata, ewd);
    chk("cyc_busy", busy, ebusy);
    chk("cyc_press_pulse", press_pulse, epulse);
    chk("cyc_press_count", press_count, reset ? 0 : m_cnt);
`ifdef BUTTON_LEVEL_READBACK_EN
    chk("cyc_button_level", button_level, reset ? 1'b0 : m_lvl);
`endif
  end

  // mode 0: clean press, 1: press + 3 bounce edges during hold-off,
  // 2: press + edge captured as S_HOLD_CLR is entered, 3: spurious irq.
  task automatic press(input int mode, output int lat_p, output int lat_b,
                       output int npulse, output int nclr);
    int n_irq;
    bit seen_busy;
    n_irq = -1; lat_p = -1; lat_b = -1; npulse = 0; nclr = 0; seen_busy = 1'b0;
    if (mode == 3) irq_force = 1'b1;
    else           in_port   = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (irq && n_irq < 0) n_irq = n;
      if (press_pulse) begin
        npulse++;
        if (lat_p < 0 && n_irq >= 0) lat_p = n - n_irq;
      end
      if (avm_chipselect && !avm_write_n && avm_address == 2'd3) nclr++;
      if (busy) seen_busy = 1'b1;
      else if (seen_busy && lat_b < 0 && n_irq >= 0) lat_b = n - n_irq;
      irq_force = 1'b0;
      case (mode)
        1:       in_port = (n == 5 || n == 7 || n == 9) ? 1'b0 : 1'b1;
        2:       in_port = (n == 12) ? 1'b0 : 1'b1;
        default: in_port = 1'b1;
      endcase
    end
  endtask

  initial begin
    int lp, lb, np, nc;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Init sequence after reset release.
    @(negedge clk);
    chk("init1_address", avm_address, 2);
    chk("init1_cs_wn", {avm_chipselect, avm_write_n}, 2'b10);
    chk("init1_data", avm_writedata, 1);
    @(negedge clk);
    chk("init2_address", avm_address, 3);
    chk("init2_data", avm_writedata, 1);
    @(negedge clk);
    chk("init_busy", busy, 0);
    chk("init_cs", avm_chipselect, 0);
    chk("init_count", press_count, 0);
    repeat (3) @(negedge clk);

    // First press with bounce during hold-off.
    press(1, lp, lb, np, nc);
    chk("press1_pulse_latency", lp, 3);
    chk("press1_busy_latency", lb, BUSY_LAT);
    chk("press1_pulses", np, 1);
    chk("press1_clears", nc, 2);
    chk("press1_count", press_count, 1);
    chk("bounce_irq_cleared", irq, 0);

    // Spurious irq: no count, clears still issued.
    press(3, lp, lb, np, nc);
    chk("spur_pulses", np, 0);
    chk("spur_clears", nc, 2);
    chk("spur_count", press_count, 1);

    // Wrap of the 2-bit counter: 2, 3, 0, 1.
    press(0, lp, lb, np, nc);
    chk("wrap_count_2", press_count, 2);
    press(2, lp, lb, np, nc);
    chk("holdclr_edge_pulses", np, 1);
    chk("wrap_count_3", press_count, 3);
    chk("holdclr_edge_irq", irq, 0);
    press(0, lp, lb, np, nc);
    chk("wrap_count_0", press_count, 0);
    press(0, lp, lb, np, nc);
    chk("wrap_count_1", press_count, 1);

    // Reset asserted while in hold-off.
    in_port = 1'b0;
    @(negedge clk);
    in_port = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_reset_count", press_count, 2);
    #1 reset = 1'b1;
    #1;
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_write_n", avm_write_n, 1);
    chk("rst_address", avm_address, 0);
    chk("rst_writedata", avm_writedata, 0);
    chk("rst_count", press_count, 0);
    chk("rst_pulse", press_pulse, 0);
    chk("rst_busy", busy, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("reinit_busy", busy, 0);
    chk("reinit_count", press_count, 0);

    press(0, lp, lb, np, nc);
    chk("after_reset_count", press_count, 1);
`ifdef BUTTON_LEVEL_READBACK_EN
    chk("button_level_high", button_level, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
